// File: rtl/bitmap_pixel_fetch.sv
// Fetches the 1bpp source pixel for the tracker position from synchronous frame RAM,
// with SCALE upscaling and fixed 2-cycle latency. Define BITMAP_DOUBLE_BUFFER_EN for bank swapping.
module bitmap_pixel_fetch #(
  parameter int unsigned X_LINE_WIDTH = 640,
  parameter int unsigned Y_LINE_WIDTH = 480,
  parameter int unsigned X_DATA_WIDTH = $clog2(X_LINE_WIDTH),
  parameter int unsigned Y_DATA_WIDTH = $clog2(Y_LINE_WIDTH),
  parameter int unsigned SCALE        = 4,
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned BANK_WORDS   = 1024,
  parameter int unsigned ADDR_W       = $clog2(BANK_WORDS) + 1
) (
  input  logic                    CLK_40,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic [X_DATA_WIDTH:0]   x_pos,
  input  logic [Y_DATA_WIDTH:0]   y_pos,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [WORD_W-1:0]       mem_rdata,
  input  logic                    frame_ready,
  output logic                    frame_ack,
  output logic                    write_bank,
  output logic                    pixel_out,
  output logic                    pixel_valid
);

  localparam int unsigned XW            = X_DATA_WIDTH + 1;
  localparam int unsigned YW            = Y_DATA_WIDTH + 1;
  localparam int unsigned FRAME_W       = X_LINE_WIDTH / SCALE;
  localparam int unsigned WORDS_PER_ROW = FRAME_W / WORD_W;
  localparam int unsigned SCALE_SH      = $clog2(SCALE);
  localparam int unsigned BIT_W         = $clog2(WORD_W);
  localparam int unsigned OFF_W         = ADDR_W - 1;

  logic [XW-1:0]    xs_c;
  logic [YW-1:0]    ys_c;
  logic             in_range_c;
  logic [OFF_W-1:0] offset_c;
  logic [BIT_W-1:0] bit_c;
  logic             bank_c;

  // Source-frame coordinates, word offset within the bank and bit within the word
  always_comb begin
    xs_c       = x_pos >> SCALE_SH;
    ys_c       = y_pos >> SCALE_SH;
    in_range_c = (x_pos < XW'(X_LINE_WIDTH)) && (y_pos < YW'(Y_LINE_WIDTH));
    offset_c   = OFF_W'(ys_c) * OFF_W'(WORDS_PER_ROW) + OFF_W'(xs_c >> BIT_W);
    bit_c      = xs_c[BIT_W-1:0];
  end

`ifdef BITMAP_DOUBLE_BUFFER_EN
  logic display_bank;
  logic swap_c;
  logic swap_d;

  // Swap is taken at frame start and applies to that same pixel's address
  assign swap_c = clk_en && frame_ready && (x_pos == '0) && (y_pos == '0);
  assign bank_c = display_bank ^ swap_c;

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      display_bank <= 1'b0;
      swap_d       <= 1'b0;
      frame_ack    <= 1'b0;
      write_bank   <= 1'b1;
    end else begin
      display_bank <= bank_c;
      swap_d       <= swap_c;
      frame_ack    <= swap_d;
      write_bank   <= ~bank_c;
    end
  end
`else
  logic unused_frame_ready;

  assign unused_frame_ready = frame_ready;
  assign bank_c             = 1'b0;
  assign frame_ack          = 1'b0;
  assign write_bank         = 1'b0;
`endif

  logic             p1_valid;
  logic             p1_in_range;
  logic [BIT_W-1:0] p1_bit;
  logic             p2_valid;
  logic             p2_in_range;
  logic [BIT_W-1:0] p2_bit;

  // Issue stage, two-deep bit/range pipe aligned with RAM latency, pixel register
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      p1_valid    <= 1'b0;
      p1_in_range <= 1'b0;
      p1_bit      <= '0;
      p2_valid    <= 1'b0;
      p2_in_range <= 1'b0;
      p2_bit      <= '0;
      pixel_out   <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      mem_rd_en <= clk_en && in_range_c;
      if (clk_en && in_range_c) begin
        mem_addr <= {bank_c, offset_c};
      end
      p1_valid    <= clk_en;
      p1_in_range <= in_range_c;
      p1_bit      <= bit_c;
      p2_valid    <= p1_valid;
      p2_in_range <= p1_in_range;
      p2_bit      <= p1_bit;
      pixel_valid <= p2_valid;
      if (p2_valid) begin
        pixel_out <= p2_in_range && mem_rdata[p2_bit];
      end
    end
  end

endmodule

// File: doc/bitmap_pixel_fetch.md
# bitmap_pixel_fetch

Downstream consumer of the screen position tracker. Each `clk_en` tick it takes the current (`x_pos`, `y_pos`) and reads the 1-bit-per-pixel Bad Apple frame from synchronous frame memory, upscaling by `SCALE`. It returns a registered `pixel_out` with fixed latency for the video output stage. Optionally it double-buffers the frame store and swaps banks at frame start under a ready/ack handshake with the frame decoder.

## Interface
- `X_LINE_WIDTH`, 640, visible pixels per line; must match the tracker.
- `Y_LINE_WIDTH`, 480, visible lines per frame; must match the tracker.
- `X_DATA_WIDTH`, `$clog2(X_LINE_WIDTH)`; position ports are this+1 bits wide.
- `Y_DATA_WIDTH`, `$clog2(Y_LINE_WIDTH)`; position ports are this+1 bits wide.
- `SCALE`, 4, integer upscale factor; power of two; must divide both line widths.
- `WORD_W`, 32, frame memory word width; power of two; must divide `X_LINE_WIDTH/SCALE`.
- `BANK_WORDS`, 1024, words per bank; power of two and ≥ `WORDS_PER_ROW*(Y_LINE_WIDTH/SCALE)`.
- `ADDR_W`, `$clog2(BANK_WORDS)+1`, memory address width.
- `CLK_40`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `clk_en`  in  1  pixel-rate enable, the same signal that drives the tracker.
- `x_pos`  in  X_DATA_WIDTH+1  tracker column.
- `y_pos`  in  Y_DATA_WIDTH+1  tracker row.
- `mem_rd_en`  out  1  read strobe to synchronous RAM.
- `mem_addr`  out  ADDR_W  word address.
- `mem_rdata`  in  WORD_W  read data, valid one cycle after `mem_rd_en`.
- `frame_ready`  in  1  decoder has finished filling the write bank.
- `frame_ack`  out  1  one-cycle pulse when the bank swap is taken.
- `write_bank`  out  1  bank the decoder may write (`~display_bank`).
- `pixel_out`  out  1  pixel value, 1 = white.
- `pixel_valid`  out  1  `pixel_out` is updated this cycle.

## Operation
- Derived values: `FRAME_W = X_LINE_WIDTH/SCALE` (160); `WORDS_PER_ROW = FRAME_W/WORD_W` (5).
- Source coordinates: `xs = x_pos >> log2(SCALE)`; `ys = y_pos >> log2(SCALE)`.
- Word address: `{display_bank, ys*WORDS_PER_ROW + xs/WORD_W}`. The lower field is `ADDR_W-1` bits wide; the multiply is performed at that width, with no truncation within legal ranges.
- Bit select: `xs % WORD_W`. Bit 0 is the leftmost pixel of the word.
- Stage 0, on an edge with `clk_en`=1: register `mem_addr`, assert `mem_rd_en` for 1 cycle, and register the bit index and an in-range flag through a 2-deep pipe.
- Stage 1: the RAM returns `mem_rdata`.
- Stage 2: register `pixel_out = mem_rdata[bit]`; pulse `pixel_valid`.
- Out of range (`x_pos ≥ X_LINE_WIDTH` or `y_pos ≥ Y_LINE_WIDTH`): no read is issued, `pixel_valid` still pulses, and `pixel_out` = 0.
- With `clk_en`=0: no read is issued and `pixel_out` holds its value.
- Back-to-back `clk_en` is fully supported: one read per cycle, with no stalls.
- Bank swap (frame-start handshake):
  - On a stage-0 edge with `clk_en`=1, `x_pos`=0, `y_pos`=0 and `frame_ready`=1, `display_bank` toggles.
  - The new bank is used for that same pixel's address.
  - `frame_ack` pulses high the next cycle.
- If `frame_ready`=0 at frame start, the current bank is repeated and no ack is issued.
- `frame_ready` at any other time is ignored until the next frame start.
- The decoder must drop `frame_ready` after the ack; if it stays high, the bank toggles again at the next frame start.

## Timing
- Latency: a position sampled at edge k drives `mem_addr` after edge k; `pixel_out`/`pixel_valid` reflect it after edge k+2.
- `frame_ack` is asserted for the cycle after edge k+1, where k is the swap edge.
- `write_bank` changes in the same cycle as `display_bank`, after edge k.
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `frame_ack`=0, `display_bank`=0, `write_bank`=1, `pixel_out`=0, `pixel_valid`=0, pipe flags cleared.
- Reset mid-frame squashes both in-flight pipe stages; no `pixel_valid` follows the reset edge.
- Reset has priority over `clk_en` and `frame_ready`.

## Configuration
- `BITMAP_DOUBLE_BUFFER_EN` defined: two banks, handshake as above.
- Not defined:
  - `display_bank` is fixed at 0 and the address MSB is 0.
  - `write_bank` is tied to 0.
  - `frame_ready` is ignored and `frame_ack` is tied to 0.
  - Pixel datapath and latency are unchanged.

## Test plan
- After reset, continuous `clk_en`, memory preloaded: position (0,0) reads address 0, and `pixel_out` = word0 bit 0 two cycles later; positions (4..7, 0) read bit 1; (128, 0) reads address 1 bit 0.
- Position (639, 479) reads address 599, bit 31; the following (0, 0) wraps to address 0 with no bubble in `pixel_valid`.
- `clk_en` asserted every 3rd cycle: exactly one `mem_rd_en` and one `pixel_valid` per tick, and `pixel_out` holds between ticks.
- `BITMAP_DOUBLE_BUFFER_EN` defined, `frame_ready` raised mid-frame: no swap until the next (0, 0); then addresses gain MSB=1, `frame_ack` pulses once, and `write_bank` becomes 0.
- `BITMAP_DOUBLE_BUFFER_EN` not defined, `frame_ready` high: `frame_ack` stays 0 and every address MSB stays 0.
- Reset asserted one cycle after a read is issued: no `pixel_valid` follows, and all outputs are at their reset values on the next cycle.
